data_memory_unit: RTL and testbench

- Load/store stage directly downstream of the ALU in the single-cycle RV32I datapath.
- Takes the ALU Result as the effective address, together with rs2 store data, MemWrite and funct3.
- Performs byte/halfword/word stores with byte lanes and sign/zero-extended loads.
- Hosts a small MMIO region: GPIO output register and a free-running 64-bit cycle counter.
- Load data is combinational, consumed in the same cycle by the writeback mux; state updates on the rising clock edge.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/data_memory_unit_byte_lane_ram.sv | 30 +++
 rtl/data_memory_unit.sv | 168 ++++++++++++++++
 tb/tb_data_memory_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data memory unit:
// load/store size encodings and MMIO register offsets.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MMIO_GPIO   = 4'h0;
    localparam logic [3:0] MMIO_CYC_LO = 4'h4;
    localparam logic [3:0] MMIO_CYC_HI = 4'h8;

endpackage

// File: rtl/data_memory_unit_byte_lane_ram.sv
// Word-organised RAM with per-byte write enables.
// Ports: clk, we_i, be_i[3:0], addr_i (word index), wdata_i, rdata_o (async).
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Read is asynchronous, so a same-cycle load sees pre-edge contents.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory_unit.sv
// RV32I load/store unit: byte-lane RAM, GPIO and 64-bit cycle counter MMIO.
// Ports: clk, reset_n, ALUResult (addr), WriteData, MemWrite, MemRead, Funct3,
//        ReadData, GpioOut, Misaligned, AccessFault.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int          GPIO_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           ALUResult,
    input  logic [31:0]           WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [2:0]            Funct3,
    output logic [31:0]           ReadData,
    output logic [GPIO_WIDTH-1:0] GpioOut,
    output logic                  Misaligned,
    output logic                  AccessFault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic                  access;
    logic                  in_ram;
    logic                  in_mmio;
    logic [31:0]           mmio_off;
    logic [3:0]            mmio_sel;
    logic                  f3_ok;
    logic                  is_b;
    logic                  is_h;
    logic                  is_w;
    logic                  uns;
    logic                  mis_raw;
    logic                  flt_raw;
    logic                  bad;
    logic                  store_ok;
    logic                  ram_we;
    logic                  gpio_we;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [15:0]           lane;
    logic [GPIO_WIDTH-1:0] gpio_q;
    logic [GPIO_WIDTH-1:0] gpio_d;
    logic [63:0]           cyc_q;
    logic [63:0]           cyc_d;

    assign access = MemRead | MemWrite;

    // Address decode: RAM from 0, MMIO window of three words.
    assign in_ram   = (ALUResult >> (AW + 2)) == 32'd0;
    assign mmio_off = ALUResult - MMIO_BASE;
    assign in_mmio  = mmio_off < 32'd12;
    assign mmio_sel = mmio_off[3:0];

    always_comb begin
        f3_ok = 1'b1;
        is_b  = 1'b0;
        is_h  = 1'b0;
        is_w  = 1'b0;
        uns   = 1'b0;
        case (Funct3)
            F3_B:  is_b = 1'b1;
            F3_H:  is_h = 1'b1;
            F3_W:  is_w = 1'b1;
            F3_BU: begin
                is_b = 1'b1;
                uns  = 1'b1;
            end
            F3_HU: begin
                is_h = 1'b1;
                uns  = 1'b1;
            end
            default: f3_ok = 1'b0;
        endcase
        // Unsigned variants have no store form.
        if (MemWrite && uns) begin
            f3_ok = 1'b0;
        end
    end

    // Raw conditions are unqualified so ReadData is zero whenever the
    // access would not decode cleanly, even without MemRead.
    assign mis_raw = (is_h & ALUResult[0])
                   | (is_w & (ALUResult[1:0] != 2'b00));

    assign flt_raw = ~(in_ram | in_mmio)
                   | ~f3_ok
                   | (in_mmio & ~is_w)
                   | (MemWrite & in_mmio & (mmio_sel != MMIO_GPIO));

    assign bad         = mis_raw | flt_raw;
    assign Misaligned  = access & mis_raw;
    assign AccessFault = access & flt_raw;

    // Store path: lanes replicated so the byte enables pick the right copy.
    always_comb begin
        ram_be    = 4'b0000;
        ram_wdata = {4{WriteData[7:0]}};
        if (is_w) begin
            ram_be    = 4'b1111;
            ram_wdata = WriteData;
        end else if (is_h) begin
            ram_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{WriteData[15:0]}};
        end else if (is_b) begin
            ram_be = 4'b0001 << ALUResult[1:0];
        end
    end

    assign store_ok = MemWrite & reset_n & ~bad;
    assign ram_we   = store_ok & in_ram;
    assign gpio_we  = store_ok & in_mmio;

    byte_lane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ALUResult[AW+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Load path: shift the addressed byte/half down to bit 0, then extend.
    assign lane = 16'(ram_rdata >> {ALUResult[1:0], 3'b000});

    always_comb begin
        ReadData = 32'd0;
        if (!bad) begin
            if (in_mmio) begin
                case (mmio_sel)
                    MMIO_GPIO:   ReadData = 32'(gpio_q);
                    MMIO_CYC_LO: ReadData = cyc_q[31:0];
                    MMIO_CYC_HI: ReadData = cyc_q[63:32];
                    default:     ReadData = 32'd0;
                endcase
            end else begin
                unique case (1'b1)
                    is_w: ReadData = ram_rdata;
                    is_h: ReadData = {{16{~uns & lane[15]}}, lane};
                    is_b: ReadData = {{24{~uns & lane[7]}}, lane[7:0]};
                endcase
            end
        end
    end

    assign gpio_d = gpio_we ? WriteData[GPIO_WIDTH-1:0] : gpio_q;
    assign cyc_d  = cyc_q + 64'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gpio_q <= '0;
            cyc_q  <= '0;
        end else begin
            gpio_q <= gpio_d;
            cyc_q  <= cyc_d;
        end
    end

    assign GpioOut = gpio_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Testbench for data_memory_unit: directed steps then random traffic
// against a byte-array reference model.
module tb_data_memory_unit;
    import dmem_pkg::*;

    localparam int          DW = 1024;
    localparam logic [31:0] MB = 32'h8000_0000;
    localparam int          GW = 8;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DW);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   ALUResult;
    logic [31:0]   WriteData;
    logic          MemWrite;
    logic          MemRead;
    logic [2:0]    Funct3;
    logic [31:0]   ReadData;
    logic [GW-1:0] GpioOut;
    logic          Misaligned;
    logic          AccessFault;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    m_mem [0:4*DW-1];
    logic [GW-1:0] m_gpio;
    logic [63:0]   m_cyc;
    logic [31:0]   e_rd;
    logic          e_mis;
    logic          e_flt;
    bit            chk_rd;

    data_memory_unit #(
        .DEPTH_WORDS (DW),
        .MMIO_BASE   (MB),
        .GPIO_WIDTH  (GW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .Funct3      (Funct3),
        .ReadData    (ReadData),
        .GpioOut     (GpioOut),
        .Misaligned  (Misaligned),
        .AccessFault (AccessFault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Reference model: access rules stated directly on the byte address.
    function automatic void model(input logic [31:0] a, input logic [2:0] f,
                                  input logic w, input logic r,
                                  output logic [31:0] rd,
                                  output logic mis, output logic flt);
        int          sz;
        bit          sgn;
        bit          f_ok;
        bit          in_ram;
        bit          in_io;
        bit          m_raw;
        bit          f_raw;
        logic [31:0] v;
        sz     = size_of(f);
        sgn    = (f == 3'd0) || (f == 3'd1);
        f_ok   = (sz != 0) && !(w && (f == 3'd4 || f == 3'd5));
        in_ram = a < RAM_BYTES;
        in_io  = (a >= MB) && (a <= MB + 32'd11);
        m_raw  = (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
        f_raw  = !(in_ram || in_io) || !f_ok || (in_io && sz != 4)
               || (w && in_io && a != MB);
        mis = (w | r) & m_raw;
        flt = (w | r) & f_raw;
        rd  = 32'd0;
        if (!m_raw && !f_raw) begin
            if (in_io) begin
                if (a == MB)
                    rd = 32'(m_gpio);
                else if (a == MB + 32'd4)
                    rd = m_cyc[31:0];
                else
                    rd = m_cyc[63:32];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++)
                    v = v | (32'(m_mem[a + 32'(i)]) << (8 * i));
                if (sgn && v[8*sz-1])
                    v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v;
            end
        end
    endfunction

    task automatic drive(input logic w, input logic r, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        MemWrite  = w;
        MemRead   = r;
        Funct3    = f;
        ALUResult = a;
        WriteData = d;
        #1;
        model(a, f, w, r, e_rd, e_mis, e_flt);
        if (chk_rd)
            chk($sformatf("rdata@%h", a), 64'(ReadData), 64'(e_rd));
        chk($sformatf("mis@%h", a), 64'(Misaligned), 64'(e_mis));
        chk($sformatf("flt@%h", a), 64'(AccessFault), 64'(e_flt));
        chk("gpio", 64'(GpioOut), 64'(m_gpio));
    endtask

    task automatic tick();
        int sz;
        if (!reset_n) begin
            m_gpio = '0;
            m_cyc  = 64'd0;
        end else begin
            if (MemWrite && !e_mis && !e_flt) begin
                sz = size_of(Funct3);
                if (ALUResult < RAM_BYTES) begin
                    for (int i = 0; i < sz; i++)
                        m_mem[ALUResult + 32'(i)] = WriteData[8*i +: 8];
                end else begin
                    m_gpio = WriteData[GW-1:0];
                end
            end
            m_cyc = m_cyc + 64'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        int          sel;

        chk_rd    = 1'b1;
        e_mis     = 1'b0;
        e_flt     = 1'b0;
        reset_n   = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Funct3    = F3_W;
        ALUResult = 32'd0;
        WriteData = 32'd0;
        @(posedge clk);
        #1;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (5) tick();

        drive(0, 1, F3_W, MB + 32'd4, 0);
        chk("cyc_lo_after_reset", 64'(ReadData), 64'd5);
        chk("gpio_after_reset", 64'(GpioOut), 64'd0);
        tick();
        drive(0, 1, F3_W, MB + 32'd8, 0);
        chk("cyc_hi_after_reset", 64'(ReadData), 64'd0);
        tick();

        chk_rd = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drive(1, 0, F3_W, 32'(4 * i), $urandom);
            tick();
        end
        chk_rd = 1'b1;

        drive(1, 0, F3_W, 32'h10, 32'h1122_3344);
        tick();
        drive(1, 0, F3_B, 32'h11, 32'h0000_00AB);
        tick();
        drive(0, 1, F3_W, 32'h10, 0);
        chk("lw_lanes", 64'(ReadData), 64'h1122_AB44);
        tick();
        drive(0, 1, F3_B, 32'h11, 0);
        chk("lb", 64'(ReadData), 64'hFFFF_FFAB);
        tick();
        drive(0, 1, F3_BU, 32'h11, 0);
        chk("lbu", 64'(ReadData), 64'h0000_00AB);
        tick();
        drive(0, 1, F3_H, 32'h12, 0);
        chk("lh_hi", 64'(ReadData), 64'h0000_1122);
        tick();

        drive(1, 0, F3_H, 32'h20, 32'h0000_8001);
        tick();
        drive(0, 1, F3_H, 32'h20, 0);
        chk("lh_sext", 64'(ReadData), 64'hFFFF_8001);
        tick();
        drive(0, 1, F3_HU, 32'h20, 0);
        chk("lhu_zext", 64'(ReadData), 64'h0000_8001);
        tick();

        drive(1, 0, F3_W, 32'h30, 32'hCAFE_F00D);
        tick();
        drive(1, 0, F3_W, 32'h32, 32'hDEAD_BEEF);
        chk("sw_misaligned", 64'(Misaligned), 64'd1);
        tick();
        drive(0, 1, F3_W, 32'h30, 0);
        chk("sw_mis_dropped", 64'(ReadData), 64'hCAFE_F00D);
        tick();
        drive(0, 1, F3_H, 32'h31, 0);
        chk("lh_misaligned", 64'(Misaligned), 64'd1);
        chk("lh_mis_rdata", 64'(ReadData), 64'd0);
        tick();

        drive(1, 0, F3_W, 32'h2000, 32'h5555_5555);
        chk("sw_out_of_range", 64'(AccessFault), 64'd1);
        tick();
        drive(1, 0, F3_W, MB + 32'd4, 32'h0);
        chk("sw_counter", 64'(AccessFault), 64'd1);
        tick();
        drive(0, 1, F3_W, MB + 32'd4, 0);
        tick();
        drive(1, 0, F3_B, MB, 32'h0000_00EE);
        chk("sb_mmio", 64'(AccessFault), 64'd1);
        tick();
        drive(0, 1, 3'b011, 32'h10, 0);
        chk("f3_invalid", 64'(AccessFault), 64'd1);
        chk("f3_inv_rdata", 64'(ReadData), 64'd0);
        tick();

        drive(1, 0, F3_W, MB, 32'h0000_01A5);
        tick();
        drive(0, 0, F3_W, 32'h0, 0);
        chk("gpio_write", 64'(GpioOut), 64'hA5);
        tick();

        reset_n = 1'b0;
        drive(1, 0, F3_W, MB, 32'h0000_0077);
        tick();
        drive(1, 0, F3_W, 32'h10, 32'hFFFF_FFFF);
        tick();
        reset_n = 1'b1;
        drive(0, 1, F3_W, 32'h10, 0);
        chk("ram_kept_in_reset", 64'(ReadData), 64'h1122_AB44);
        chk("gpio_reset", 64'(GpioOut), 64'd0);
        tick();

        drive(1, 0, F3_W, 32'h40, 32'h0BAD_CAFE);
        tick();
        drive(1, 1, F3_W, 32'h40, 32'h1234_5678);
        chk("rdw_old", 64'(ReadData), 64'h0BAD_CAFE);
        tick();
        drive(0, 1, F3_W, 32'h40, 0);
        chk("rdw_new", 64'(ReadData), 64'h1234_5678);
        tick();

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)
                ra = 32'($urandom_range(0, 255));
            else if (sel < 9)
                ra = MB + 32'($urandom_range(0, 15));
            else
                ra = 32'h0000_1000 + 32'($urandom_range(0, 32'h7FFF_0000));
            rf      = 3'($urandom_range(0, 7));
            reset_n = ($urandom_range(0, 49) != 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rf, ra, $urandom);
            tick();
        end
        reset_n = 1'b1;
        drive(0, 1, F3_W, MB + 32'd4, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
